// File: rtl/result_display.sv
// result_display: converts one BITS-wide result to BCD by double-dabble and scans it onto an 8-digit seven-segment display.
//   clk, reset            : clock, synchronous active-high reset
//   result_valid, result  : one result per handshake, accepted only while busy is low
//   signed_in             : 1 = treat result as two's complement
//   busy                  : conversion in progress
//   anode, cathode        : active-low digit enables and segments {dp,g,f,e,d,c,b,a}
module result_display #(
   parameter int BITS        = 16,
   parameter int REFRESH_DIV = 100000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            result_valid,
   input  logic [BITS-1:0] result,
   input  logic            signed_in,
   output logic            busy,
   output logic [7:0]      anode,
   output logic [7:0]      cathode
);
   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] CONVERT = 1'b1;
   localparam int RW = $clog2(REFRESH_DIV);

   logic [0:0]     state_q, state_d;
   logic [4:0]     cnt_q, cnt_d;
   logic [27:0]    bcd_q, bcd_d, digits_q, digits_d, adj;
   logic [BITS-1:0] mag_q, mag_d;
   logic           neg_pend_q, neg_pend_d, neg_q, neg_d;
   logic [RW-1:0]  refresh_q, refresh_d;
   logic [2:0]     idx_q, idx_d, msd;
   logic [7:0]     anode_q, anode_d, cathode_q, cathode_d;
   logic [BITS+27:0] sh;
   logic [31:0]    dig_ext;
   logic [3:0]     nib;
   logic           accept, last, wrap, neg_in;

   function automatic logic [7:0] seg(input logic [3:0] d);
      case (d)
         4'd0: seg = 8'hC0;
         4'd1: seg = 8'hF9;
         4'd2: seg = 8'hA4;
         4'd3: seg = 8'hB0;
         4'd4: seg = 8'h99;
         4'd5: seg = 8'h92;
         4'd6: seg = 8'h82;
         4'd7: seg = 8'hF8;
         4'd8: seg = 8'h80;
         4'd9: seg = 8'h90;
         default: seg = 8'hFF;
      endcase
   endfunction

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < 7; i++)
         adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      sh         = {adj, mag_q} << 1;
      neg_in     = signed_in & result[BITS-1];
      accept     = state_q == IDLE && result_valid;
      last       = state_q == CONVERT && cnt_q == 5'(BITS-1);
      state_d    = accept ? CONVERT : last ? IDLE : state_q;
      cnt_d      = state_q == CONVERT ? cnt_q + 5'd1 : 5'd0;
      bcd_d      = accept ? '0 : state_q == CONVERT ? sh[BITS+27:BITS] : bcd_q;
      mag_d      = accept ? (neg_in ? -result : result) : state_q == CONVERT ? sh[BITS-1:0] : mag_q;
      neg_pend_d = accept ? neg_in : neg_pend_q;
      // The final shift result goes straight to the display register, together with its sign.
      digits_d   = last ? sh[BITS+27:BITS] : digits_q;
      neg_d      = last ? neg_pend_q : neg_q;
      wrap       = refresh_q == RW'(REFRESH_DIV-1);
      refresh_d  = wrap ? '0 : refresh_q + RW'(1);
      idx_d      = wrap ? idx_q + 3'd1 : idx_q;
      dig_ext    = {4'h0, digits_q};
      nib        = dig_ext[{idx_q, 2'b00} +: 4];
      msd        = 3'd0;
      for (int i = 1; i < 7; i++)
         if (digits_q[4*i +: 4] != 4'd0) msd = 3'(i);
      anode_d    = ~(8'd1 << idx_q);
      cathode_d  = idx_q <= msd ? seg(nib) : (neg_q && idx_q == msd + 3'd1) ? 8'hBF : 8'hFF;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bcd_q      <= '0;
         mag_q      <= '0;
         neg_pend_q <= 1'b0;
         digits_q   <= '0;
         neg_q      <= 1'b0;
         refresh_q  <= '0;
         idx_q      <= '0;
         anode_q    <= 8'hFF;
         cathode_q  <= 8'hFF;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bcd_q      <= bcd_d;
         mag_q      <= mag_d;
         neg_pend_q <= neg_pend_d;
         digits_q   <= digits_d;
         neg_q      <= neg_d;
         refresh_q  <= refresh_d;
         idx_q      <= idx_d;
         anode_q    <= anode_d;
         cathode_q  <= cathode_d;
      end
   end

   assign busy    = state_q == CONVERT;
   assign anode   = anode_q;
   assign cathode = cathode_q;
endmodule

// File: tb/tb_result_display.sv
// tb_result_display: randomized and directed checks of result_display against a decimal-arithmetic display model.
module tb_result_display;
   localparam int BITS = 16;
   localparam int DIV  = 4;
   localparam logic [7:0] GL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        result_valid = 1'b0;
   logic        signed_in = 1'b0;
   logic [15:0] result = '0;
   logic        busy;
   logic [7:0]  anode, cathode;
   logic [7:0]  exp_g [8];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   result_display #(.BITS(BITS), .REFRESH_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .result_valid(result_valid), .result(result),
      .signed_in(signed_in), .busy(busy), .anode(anode), .cathode(cathode)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_expected(input logic [15:0] r, input logic s);
      bit neg;
      int unsigned m, t;
      int len;
      neg = s && r[15];
      m = neg ? 32'd65536 - 32'(r) : 32'(r);
      len = 1;
      t = m / 10;
      while (t > 0) begin
         len++;
         t = t / 10;
      end
      t = m;
      for (int i = 0; i < 8; i++) begin
         exp_g[i] = i < len ? GL[t % 10] : (i == len && neg) ? 8'hBF : 8'hFF;
         t = t / 10;
      end
   endtask

   task automatic check_cycles(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         int idx;
         idx = -1;
         for (int i = 0; i < 8; i++) if (anode == ~(8'd1 << i)) idx = i;
         checks++;
         if (idx < 0) begin
            errors++;
            $display("FAIL %s anode: got %h, required exactly one low bit", tag, anode);
         end else begin
            checks++;
            if (cathode !== exp_g[idx]) begin
               errors++;
               $display("FAIL %s digit%0d cathode: got %h, required %h", tag, idx, cathode, exp_g[idx]);
            end
         end
         step;
      end
   endtask

   task automatic wait_idle;
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 60) begin
         step;
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle busy: got %b, required 0 within 60 cycles", busy);
      end
   endtask

   task automatic convert(input logic [15:0] r, input logic s, input string tag);
      wait_idle;
      result_valid = 1'b1;
      result = r;
      signed_in = s;
      step;
      result_valid = 1'b0;
      result = 16'($urandom);
      signed_in = 1'($urandom);
      for (int k = 1; k <= 16; k++) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy cycle %0d: got %b, required 1", tag, k, busy);
         end
         step;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy cycle 17: got %b, required 0", tag, busy);
      end
      step;
      set_expected(r, s);
      check_cycles(32, tag);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step;
      step;
      checks++;
      if (anode !== 8'hFF || cathode !== 8'hFF || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset outputs: got anode=%h cathode=%h busy=%b, required FF FF 0", anode, cathode, busy);
      end
      reset = 1'b0;
      step;
      for (int k = 0; k < 36; k++) begin
         logic [7:0] ea, ec;
         ea = ~(8'd1 << ((k / DIV) % 8));
         ec = ((k / DIV) % 8) == 0 ? 8'hC0 : 8'hFF;
         checks++;
         if (anode !== ea || cathode !== ec) begin
            errors++;
            $display("FAIL reset scan cycle %0d: got anode=%h cathode=%h, required %h %h", k, anode, cathode, ea, ec);
         end
         step;
      end
   endtask

   task automatic test_values;
      convert(16'd12345, 1'b0, "u12345");
      convert(16'hFFF9, 1'b1, "s_minus7");
      convert(16'hFFF9, 1'b0, "u65529");
      convert(16'h8000, 1'b1, "s_min");
      convert(16'd0, 1'b1, "zero");
      convert(16'hFFFF, 1'b0, "u_max");
      convert(16'd10000, 1'b1, "s10000");
   endtask

   task automatic test_random;
      for (int n = 0; n < 10; n++) convert(16'($urandom), 1'($urandom), "random");
   endtask

   task automatic test_back_to_back;
      wait_idle;
      set_expected(16'd111, 1'b0);
      result_valid = 1'b1;
      result = 16'd111;
      signed_in = 1'b0;
      step;
      for (int k = 1; k <= 16; k++) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b busy cycle %0d: got %b, required 1", k, busy);
         end
         result_valid = 1'b1;
         result = 16'd222;
         step;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b completion busy: got %b, required 0", busy);
      end
      result = 16'd333;
      step;
      result_valid = 1'b0;
      check_cycles(16, "b2b_111");
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b second busy: got %b, required 0", busy);
      end
      step;
      set_expected(16'd333, 1'b0);
      check_cycles(32, "b2b_333");
   endtask

   task automatic test_reset_abort;
      convert(16'd99, 1'b0, "pre99");
      wait_idle;
      result_valid = 1'b1;
      result = 16'd54321;
      signed_in = 1'b0;
      step;
      result_valid = 1'b0;
      check_cycles(7, "hold99");
      reset = 1'b1;
      step;
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || anode !== 8'hFF || cathode !== 8'hFF) begin
         errors++;
         $display("FAIL abort reset: got busy=%b anode=%h cathode=%h, required 0 FF FF", busy, anode, cathode);
      end
      step;
      set_expected(16'd0, 1'b0);
      check_cycles(48, "abort_zero");
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort busy: got %b, required 0", busy);
      end
   endtask

   initial begin
      test_reset;
      test_values;
      test_random;
      test_back_to_back;
      test_reset_abort;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/result_display.md
# result_display

Sequential display back-end for the arithmetic datapath. It accepts one `BITS`-wide operation result per valid/busy handshake and converts it to BCD with an iterative shift-add-3 (double-dabble) engine. It then time-multiplexes the decimal value, with optional minus sign and leading-zero blanking, onto the board's 8-digit common-anode seven-segment display. It sits directly downstream of the operation unit and consumes its `word_t` result.

## Interface
- `BITS`, 16: result width; legal range 4..20 (magnitude always fits 7 decimal digits plus sign).
- `REFRESH_DIV`, 100000: clock cycles each digit stays lit; must be ≥ 2.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `result_valid`  in  1  result present this cycle.
- `result`  in  BITS  value to display.
- `signed_in`  in  1  sampled with `result`; 1 = two's-complement interpretation.
- `busy`  out  1  conversion in progress; `result_valid` ignored while high.
- `anode`  out  8  digit enables, active low, bit i = digit i (digit 0 rightmost).
- `cathode`  out  8  segments, active low, bit order {dp,g,f,e,d,c,b,a}.

## Operation
- FSM states: IDLE, CONVERT.
  - IDLE: `result_valid` && !`busy` accepts the input and goes to CONVERT.
  - CONVERT: runs exactly BITS cycles, then returns to IDLE.
- On accept, latch the sign and magnitude:
  - neg = `signed_in` & `result[BITS-1]`.
  - mag = neg ? -`result` : `result`, as an unsigned BITS-bit value. -2^(BITS-1) yields magnitude 2^(BITS-1), e.g. 16'h8000 → 32768.
- CONVERT, each cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift the {bcd, mag} register left by 1.
  - BCD register is 28 bits (7 nibbles).
- Completion: the displayed-digit register and neg flag update atomically. The previous value stays on the display for the whole conversion.
- Digit rendering, for msd = index of the highest nonzero BCD nibble (0 if the value is 0):
  - Digits ≤ msd show the decimal glyph.
  - Digit msd+1 shows minus (g only, 8'hBF) when neg; otherwise blank.
  - All higher digits blank (8'hFF).
  - Digit 0 is always shown, so zero displays "0".
  - dp is always off.
- Glyphs 0-9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex).
- Scanning:
  - Refresh counter runs 0..`REFRESH_DIV`-1.
  - On wrap, scan index advances 0→7→0.
  - `anode` = ~(1 << index); `cathode` = glyph for that index.
  - Both are registered.

## Timing
- Reset values:
  - `busy`=0, `anode`=8'hFF, `cathode`=8'hFF.
  - Scan index=0, refresh counter=0, stored digits=0, neg=0.
- First cycle after reset deasserts: `anode`=8'hFE, `cathode`=8'hC0.
- Accept at edge T:
  - `busy`=1 from T+1 through T+BITS.
  - `busy`=0 and new digits visible at T+BITS+1.
  - Total latency BITS+1 cycles (17 for BITS=16).
- `result_valid` with `busy`=0 in the completion cycle is accepted (back-to-back throughput BITS+1).
- `result_valid` while `busy`=1 is dropped with no effect.
- Displayed-value change takes effect at the next registered output update; the scan index is not disturbed.
- Scan: each digit lit exactly `REFRESH_DIV` cycles; full frame 8×`REFRESH_DIV` cycles; exactly one anode low at all times outside reset.
- Reset mid-conversion aborts it: IDLE, `busy`=0, stored digits cleared to 0 (displays "0").
- `result` and `signed_in` are don't-care when not accepted.

## Test plan
Bench runs with BITS=16, REFRESH_DIV=4.
- Reset → `anode`=FF, `cathode`=FF during reset; one cycle later `anode`=FE, `cathode`=C0; `anode` then steps FE, FD, FB… every 4 cycles and wraps to FE after 32 cycles.
- `result`=16'd12345, `signed_in`=0 → `busy` high 16 cycles, drops 17 cycles after accept. Scan shows digits 0..4 = 5,4,3,2,1 (92, 99, B0, A4, F9); digits 5..7 = FF.
- `result`=16'hFFF9, `signed_in`=1 (−7) → digit 0 = F8, digit 1 = BF, digits 2..7 = FF. Same value with `signed_in`=0 shows 65529.
- `result`=16'h8000, `signed_in`=1 → magnitude 32768 with minus on digit 5. `result`=0 → only digit 0 lit, C0.
- Pulse `result_valid` with 111 at accept, then 222 on every busy cycle, then 333 on the completion cycle → 222 ignored; 111 displayed, then 333 after another 17 cycles.
- Assert `reset` on cycle 8 of converting 54321 while 99 is displayed → `busy`=0; display reverts to "0"; 54321 never appears.
